// File: rtl/qracc_bitserial_mac.sv
// Bit-serial MAC sequencer: streams one multi-bit input vector into the array one
// bit plane per cycle (LSB first) and shift-accumulates the per-column ADC codes.
module qracc_bitserial_mac #(
  parameter int  numRows      = 128,
  parameter int  numCols      = 32,
  parameter int  numAdcBits   = 4,
  parameter int  maxInputBits = 8,
  parameter int  numCfgBits   = 8,
  parameter int  adcLatency   = 1,
  localparam int accBits      = numAdcBits + maxInputBits + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numCfgBits-1:0]           n_input_bits_cfg,
  input  logic                            signed_cfg,
  input  logic                            binary_cfg,
  input  logic                            x_valid_i,
  output logic                            x_ready_o,
  input  logic [numRows*maxInputBits-1:0] x_data_i,
  output logic                            mac_en_o,
  output logic [numRows-1:0]              data_p_o,
  output logic [numRows-1:0]              data_n_o,
  input  logic [numCols*numAdcBits-1:0]   adc_out_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [numCols*accBits-1:0]      out_data_o
);

  localparam int idxBits = (maxInputBits > 1) ? $clog2(maxInputBits) : 1;
  localparam logic [numCfgBits-1:0] maxCfg = numCfgBits'(maxInputBits);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, OUT} state_t;

  state_t state, state_next;
  logic   x_ready, mac_en, out_valid, accept, last_code;

  logic [maxInputBits-1:0] x_reg [numRows];
  logic [idxBits-1:0]      n_last, plane, cfg_last;
  logic [numCfgBits-1:0]   cfg_minus1;
  logic                    signed_mode, binary_mode;

  logic                    tag_valid [adcLatency];
  logic                    tag_last  [adcLatency];
  logic [idxBits-1:0]      tag_idx   [adcLatency];

  logic signed [accBits-1:0] acc  [numCols];
  logic signed [accBits-1:0] term [numCols];
  logic [numAdcBits-1:0]     code;

  assign accept    = x_valid_i & x_ready;
  assign last_code = tag_valid[adcLatency-1] & tag_last[adcLatency-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    x_ready    = 1'b0;
    mac_en     = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        x_ready = 1'b1;
        if (x_valid_i) state_next = DRIVE;
      end
      DRIVE: begin
        mac_en = 1'b1;
        if (plane == n_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_code) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset forces every output to its idle value combinationally, even mid-transaction.
  assign x_ready_o   = x_ready & ~rst;
  assign mac_en_o    = mac_en & ~rst;
  assign out_valid_o = out_valid & ~rst;

  // Zero and out-of-range precisions clamp to 1 and maxInputBits planes.
  always_comb begin
    cfg_minus1 = n_input_bits_cfg - numCfgBits'(1);
    if (n_input_bits_cfg == '0)         cfg_last = '0;
    else if (n_input_bits_cfg > maxCfg) cfg_last = idxBits'(maxInputBits - 1);
    else                                cfg_last = idxBits'(cfg_minus1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plane       <= '0;
      n_last      <= '0;
      signed_mode <= 1'b0;
      binary_mode <= 1'b0;
      for (int r = 0; r < numRows; r++) x_reg[r] <= '0;
    end else if (accept) begin
      plane       <= '0;
      n_last      <= cfg_last;
      signed_mode <= signed_cfg;
      binary_mode <= binary_cfg;
      for (int r = 0; r < numRows; r++)
        x_reg[r] <= x_data_i[r*maxInputBits +: maxInputBits];
    end else if (state == DRIVE) begin
      plane <= plane + idxBits'(1);
    end
  end

  // Each driven plane carries its index through a delay line matching the ADC latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < adcLatency; k++) begin
        tag_valid[k] <= 1'b0;
        tag_last[k]  <= 1'b0;
        tag_idx[k]   <= '0;
      end
    end else begin
      tag_valid[0] <= (state == DRIVE);
      tag_last[0]  <= (plane == n_last);
      tag_idx[0]   <= plane;
      for (int k = 1; k < adcLatency; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_last[k]  <= tag_last[k-1];
        tag_idx[k]   <= tag_idx[k-1];
      end
    end
  end

  always_comb begin
    code = '0;
    for (int c = 0; c < numCols; c++) begin
      code    = adc_out_i[c*numAdcBits +: numAdcBits];
      term[c] = {{(accBits-numAdcBits){code[numAdcBits-1]}}, code} << tag_idx[adcLatency-1];
    end
  end

  // In signed mode the MSB plane carries negative weight.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int c = 0; c < numCols; c++) acc[c] <= '0;
    end else if (tag_valid[adcLatency-1]) begin
      for (int c = 0; c < numCols; c++)
        acc[c] <= (signed_mode && tag_last[adcLatency-1]) ? acc[c] - term[c] : acc[c] + term[c];
    end
  end

  always_comb begin
    data_p_o = '0;
    data_n_o = '0;
    if (mac_en_o) begin
      for (int r = 0; r < numRows; r++) begin
        data_p_o[r] = x_reg[r][plane];
        data_n_o[r] = ~x_reg[r][plane] & ~binary_mode;
      end
    end
  end

  always_comb begin
    out_data_o = '0;
    if (!rst) begin
      for (int c = 0; c < numCols; c++) out_data_o[c*accBits +: accBits] = acc[c];
    end
  end

endmodule

// File: tb/tb_qracc_bitserial_mac.sv
// Directed bench for qracc_bitserial_mac: a registered ADC model returns per-plane
// codes and column sums are compared with hand-computed totals.
`timescale 1ns/1ps
module tb_qracc_bitserial_mac;
  localparam int numRows      = 128;
  localparam int numCols      = 32;
  localparam int numAdcBits   = 4;
  localparam int maxInputBits = 8;
  localparam int numCfgBits   = 8;
  localparam int adcLatency   = 1;
  localparam int accBits      = numAdcBits + maxInputBits + 1;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic [numCfgBits-1:0]           n_input_bits_cfg = '0;
  logic                            signed_cfg = 1'b0;
  logic                            binary_cfg = 1'b0;
  logic                            x_valid_i = 1'b0;
  logic                            x_ready_o;
  logic [numRows*maxInputBits-1:0] x_data_i = '0;
  logic                            mac_en_o;
  logic [numRows-1:0]              data_p_o;
  logic [numRows-1:0]              data_n_o;
  logic [numCols*numAdcBits-1:0]   adc_out_i = '0;
  logic                            out_valid_o;
  logic                            out_ready_i = 1'b0;
  logic [numCols*accBits-1:0]      out_data_o;

  int errors = 0;
  int checks = 0;
  int evenCodes [8];
  int oddCodes  [8];
  int planeCnt = 0;
  logic [maxInputBits-1:0] xVals [numRows];

  qracc_bitserial_mac #(
    .numRows(numRows), .numCols(numCols), .numAdcBits(numAdcBits),
    .maxInputBits(maxInputBits), .numCfgBits(numCfgBits), .adcLatency(adcLatency)
  ) dut (
    .clk(clk), .rst(rst),
    .n_input_bits_cfg(n_input_bits_cfg), .signed_cfg(signed_cfg), .binary_cfg(binary_cfg),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_data_i(x_data_i),
    .mac_en_o(mac_en_o), .data_p_o(data_p_o), .data_n_o(data_n_o),
    .adc_out_i(adc_out_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
  );

  always #5 clk = ~clk;

  // One-cycle ADC model; outside driven planes it returns junk that must never be accumulated.
  always @(posedge clk) begin
    if (x_valid_i && x_ready_o) planeCnt <= 0;
    else if (mac_en_o)          planeCnt <= planeCnt + 1;
    for (int c = 0; c < numCols; c++)
      adc_out_i[c*numAdcBits +: numAdcBits] <= mac_en_o ?
        4'((c % 2 == 0) ? evenCodes[planeCnt % 8] : oddCodes[planeCnt % 8]) : 4'h7;
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint colVal(input int c);
    logic signed [accBits-1:0] v;
    v = out_data_o[c*accBits +: accBits];
    return longint'(v);
  endfunction

  task automatic setX(input int seed);
    for (int r = 0; r < numRows; r++) begin
      xVals[r] = 8'(r * 37 + seed);
      x_data_i[r*maxInputBits +: maxInputBits] = xVals[r];
    end
  endtask

  // Called just after a negedge; returns just after the negedge where out_valid_o is seen.
  task automatic applyStimulus(input int nCfg, input int nEff, input logic sgn,
                               input logic bin, input string tag);
    int k, macCount, planeErrs;
    x_valid_i        = 1'b1;
    n_input_bits_cfg = 8'(nCfg);
    signed_cfg       = sgn;
    binary_cfg       = bin;
    checkOutput({tag, ".x_ready"}, longint'(x_ready_o), 1);
    @(posedge clk);
    #1;
    x_valid_i        = 1'b0;
    n_input_bits_cfg = 8'd3;
    signed_cfg       = ~sgn;
    binary_cfg       = ~bin;
    k = 0;
    macCount = 0;
    planeErrs = 0;
    while (!out_valid_o && k < 40) begin
      @(negedge clk);
      k++;
      if (mac_en_o) macCount++;
      if (k <= nEff) begin
        for (int r = 0; r < numRows; r++) begin
          if (data_p_o[r] !== xVals[r][k-1]) planeErrs++;
          if (data_n_o[r] !== (bin ? 1'b0 : ~xVals[r][k-1])) planeErrs++;
        end
      end
    end
    checkOutput({tag, ".latency"}, k, nEff + adcLatency + 1);
    checkOutput({tag, ".mac_en_cycles"}, macCount, nEff);
    checkOutput({tag, ".planes"}, planeErrs, 0);
  endtask

  task automatic checkColumns(input string tag, input longint expEven, input longint expOdd);
    checkOutput({tag, ".out_valid"}, longint'(out_valid_o), 1);
    checkOutput({tag, ".col0"}, colVal(0), expEven);
    checkOutput({tag, ".col1"}, colVal(1), expOdd);
    checkOutput({tag, ".colMid"}, colVal(numCols / 2), expEven);
    checkOutput({tag, ".colLast"}, colVal(numCols - 1), expOdd);
  endtask

  task automatic releaseOutput(input string tag);
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".x_ready_after"}, longint'(x_ready_o), 1);
    checkOutput({tag, ".out_valid_after"}, longint'(out_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst.x_ready", longint'(x_ready_o), 0);
    checkOutput("rst.mac_en", longint'(mac_en_o), 0);
    checkOutput("rst.out_valid", longint'(out_valid_o), 0);
    checkOutput("rst.out_data", longint'(out_data_o != '0), 0);
    checkOutput("rst.data_p", longint'(data_p_o != '0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst.x_ready", longint'(x_ready_o), 1);
    checkOutput("post_rst.out_data", longint'(out_data_o != '0), 0);

    evenCodes = '{3, 3, 3, 3, 3, 3, 3, 3};
    oddCodes  = '{3, 3, 3, 3, 3, 3, 3, 3};
    setX(5);
    applyStimulus(1, 1, 1'b0, 1'b1, "n1");
    checkColumns("n1", 3, 3);
    releaseOutput("n1");

    evenCodes = '{1, 2, 0, 1, 0, 0, 0, 0};
    oddCodes  = '{2, 1, 1, 3, 0, 0, 0, 0};
    setX(9);
    applyStimulus(4, 4, 1'b0, 1'b1, "n4u");
    checkColumns("n4u", 13, 32);
    releaseOutput("n4u");

    applyStimulus(4, 4, 1'b1, 1'b0, "n4s");
    checkColumns("n4s", -3, -16);
    releaseOutput("n4s");

    evenCodes = '{-2, 3, 0, 0, 0, 0, 0, 0};
    oddCodes  = '{1, -1, 0, 0, 0, 0, 0, 0};
    setX(21);
    applyStimulus(2, 2, 1'b0, 1'b0, "n2");
    checkColumns("n2", 4, -1);
    releaseOutput("n2");

    evenCodes = '{5, 6, 6, 6, 6, 6, 6, 6};
    oddCodes  = '{-4, 6, 6, 6, 6, 6, 6, 6};
    applyStimulus(0, 1, 1'b0, 1'b1, "cfg0");
    checkColumns("cfg0", 5, -4);
    releaseOutput("cfg0");

    evenCodes = '{1, 1, 1, 1, 1, 1, 1, 1};
    oddCodes  = '{-1, -1, -1, -1, -1, -1, -1, -1};
    setX(77);
    applyStimulus(20, 8, 1'b0, 1'b1, "cfg20");
    checkColumns("cfg20", 255, -255);
    releaseOutput("cfg20");

    evenCodes = '{1, 1, 0, 0, 0, 0, 0, 0};
    oddCodes  = '{0, 2, 0, 0, 0, 0, 0, 0};
    applyStimulus(2, 2, 1'b0, 1'b1, "bp");
    checkColumns("bp", 3, 4);
    x_valid_i        = 1'b1;
    n_input_bits_cfg = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.hold_valid", longint'(out_valid_o), 1);
      checkOutput("bp.hold_x_ready", longint'(x_ready_o), 0);
      checkOutput("bp.hold_col0", colVal(0), 3);
      checkOutput("bp.hold_col1", colVal(1), 4);
    end
    evenCodes = '{1, 0, 2, 0, 0, 0, 0, 0};
    oddCodes  = '{-1, -1, -1, 0, 0, 0, 0, 0};
    releaseOutput("bp");
    setX(3);
    applyStimulus(3, 3, 1'b0, 1'b1, "bp2");
    checkColumns("bp2", 9, -7);
    releaseOutput("bp2");

    evenCodes = '{5, 5, 5, 5, 5, 5, 5, 5};
    oddCodes  = '{5, 5, 5, 5, 5, 5, 5, 5};
    setX(11);
    x_valid_i        = 1'b1;
    n_input_bits_cfg = 8'd8;
    signed_cfg       = 1'b0;
    binary_cfg       = 1'b0;
    @(posedge clk);
    #1;
    x_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort.mac_en_plane2", longint'(mac_en_o), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort.mac_en", longint'(mac_en_o), 0);
    checkOutput("abort.data_p", longint'(data_p_o != '0), 0);
    checkOutput("abort.data_n", longint'(data_n_o != '0), 0);
    checkOutput("abort.out_valid", longint'(out_valid_o), 0);
    checkOutput("abort.out_data", longint'(out_data_o != '0), 0);
    checkOutput("abort.x_ready", longint'(x_ready_o), 1);

    evenCodes = '{1, 1, 1, 1, 0, 0, 0, 0};
    oddCodes  = '{2, 2, 2, 2, 0, 0, 0, 0};
    setX(40);
    applyStimulus(4, 4, 1'b0, 1'b0, "after_abort");
    checkColumns("after_abort", 15, 30);
    releaseOutput("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
